// File: rtl/gpio_irq_ctrl.sv
// GPIO external-interrupt controller: latches edge pulses into pending bits,
// masks and arbitrates them (fixed or round-robin), and drives a single
// registered request to the core with a claim / end-of-interrupt handshake.
module gpio_irq_ctrl #(
  parameter int NIRQ = 16,
  parameter int IDW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      waddr_i,
  input  logic [31:0]     data_i,
  input  logic [3:0]      sel_i,
  input  logic            we_i,
  input  logic [7:0]      raddr_i,
  input  logic            rd_i,
  output logic [31:0]     data_o,
  input  logic [NIRQ-1:0] irq_i,
  output logic            irq_o,
  output logic [IDW-1:0]  irq_id_o
);

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_IEN   = 8'h04;
  localparam logic [7:0] ADDR_IPD   = 8'h08;
  localparam logic [7:0] ADDR_CLAIM = 8'h0C;
  localparam logic [7:0] ADDR_EOI   = 8'h10;

  localparam logic [IDW:0]   NIRQ_W  = (IDW+1)'(NIRQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NIRQ - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ctrl_reg;
  logic [NIRQ-1:0] ien_reg;
  logic [NIRQ-1:0] ipd_reg, ipd_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  cur_id_reg, cur_id_next;
  logic            irq_reg;
  logic [IDW-1:0]  irq_id_reg;
  logic [31:0]     data_reg;

  logic            gie, rr_mode;
  logic            wr_ctrl, wr_ien, wr_ipd, wr_eoi, rd_claim;
  logic            eoi_match;
  logic [NIRQ-1:0] elig, w1c_mask, claim_mask;
  logic [IDW-1:0]  start_ptr, win_id;
  logic            win_found;
  logic            claim_ok, abandon;
  logic [31:0]     rdata;

  // Byte enables and the upper data bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{sel_i, data_i[31:NIRQ]};

  assign gie       = ctrl_reg[0];
  assign rr_mode   = ctrl_reg[1];
  assign wr_ctrl   = we_i && (waddr_i == ADDR_CTRL);
  assign wr_ien    = we_i && (waddr_i == ADDR_IEN);
  assign wr_ipd    = we_i && (waddr_i == ADDR_IPD);
  assign wr_eoi    = we_i && (waddr_i == ADDR_EOI);
  assign rd_claim  = rd_i && (raddr_i == ADDR_CLAIM);
  assign eoi_match = (data_i[IDW-1:0] == cur_id_reg);
  assign elig      = ipd_reg & ien_reg;
  assign w1c_mask  = wr_ipd ? data_i[NIRQ-1:0] : '0;
  assign claim_mask = claim_ok ? ({{(NIRQ-1){1'b0}}, 1'b1} << cur_id_reg) : '0;
  assign start_ptr = rr_mode ? rr_ptr_reg : '0;

  // Pending bits: a new pulse always wins over a same-cycle clear.
  for (genvar gi = 0; gi < NIRQ; gi++) begin : g_ipd
    assign ipd_next[gi] = irq_i[gi] | (ipd_reg[gi] & ~w1c_mask[gi] & ~claim_mask[gi]);
  end

  // Arbiter: first eligible line found scanning upward from start_ptr, with wrap.
  always_comb begin
    logic [IDW:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NIRQ; k++) begin
      cand = {1'b0, start_ptr} + (IDW+1)'(k);
      if (cand >= NIRQ_W) cand = cand - NIRQ_W;
      if (!win_found && elig[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // FSM next state, claim acceptance, abandon detection and rr pointer update.
  always_comb begin
    state_next  = state_reg;
    cur_id_next = cur_id_reg;
    rr_ptr_next = rr_ptr_reg;
    claim_ok    = 1'b0;
    abandon     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gie && win_found) begin
          cur_id_next = win_id;
          state_next  = REQ;
        end
      end
      REQ: begin
        abandon = !gie || !ipd_reg[cur_id_reg] || !ien_reg[cur_id_reg];
        if (abandon) begin
          state_next = IDLE;
        end else if (rd_claim) begin
          claim_ok   = 1'b1;
          state_next = SERV;
        end
      end
      SERV: begin
        if (wr_eoi && eoi_match) begin
          state_next = IDLE;
          if (rr_mode) rr_ptr_next = (cur_id_reg == LAST_ID) ? '0 : cur_id_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data mux; a claim only reports valid when it is actually accepted.
  always_comb begin
    rdata = '0;
    case (raddr_i)
      ADDR_CTRL:  rdata = {30'b0, ctrl_reg};
      ADDR_IEN:   rdata = {{(32-NIRQ){1'b0}}, ien_reg};
      ADDR_IPD:   rdata = {{(32-NIRQ){1'b0}}, ipd_reg};
      ADDR_CLAIM: if (claim_ok) rdata = {1'b1, {(31-IDW){1'b0}}, cur_id_reg};
      default:    rdata = '0;
    endcase
  end

  // Control/status registers, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ctrl_reg   <= '0;
      ien_reg    <= '0;
      ipd_reg    <= '0;
      rr_ptr_reg <= '0;
      cur_id_reg <= '0;
      irq_reg    <= 1'b0;
      irq_id_reg <= '0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      ipd_reg    <= ipd_next;
      rr_ptr_reg <= rr_ptr_next;
      cur_id_reg <= cur_id_next;
      irq_reg    <= (state_reg == REQ) && !abandon && !claim_ok;
      irq_id_reg <= cur_id_reg;
      if (wr_ctrl) ctrl_reg <= data_i[1:0];
      if (wr_ien)  ien_reg  <= data_i[NIRQ-1:0];
      if (rd_i)    data_reg <= rdata;
    end
  end

  assign data_o   = data_reg;
  assign irq_o    = irq_reg;
  assign irq_id_o = irq_id_reg;

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
Interrupt controller for the GPIO[31:16] external-interrupt lines. It latches the single-cycle edge pulses from the GPIO block's gpio_trap_irq output into pending bits, masks them, and arbitrates among them with fixed or round-robin priority. It presents one registered interrupt request to the core and runs a claim/EOI handshake over the same 8-bit-offset sysio register bus the GPIO block uses.

Parameters:
NIRQ, 16, number of interrupt lines; range 2..16.
IDW, 4, width of the interrupt ID; must satisfy 2^IDW >= NIRQ.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
waddr_i  input  8  write byte offset
data_i  input  32  write data
sel_i  input  4  byte enables; ignored, all writes are full-word
we_i  input  1  write strobe, one access per cycle
raddr_i  input  8  read byte offset
rd_i  input  1  read strobe
data_o  output  32  registered read data, valid the cycle after rd_i
irq_i  input  NIRQ  edge pulses from the GPIO block (gpio_trap_irq)
irq_o  output  1  registered interrupt request to the core
irq_id_o  output  IDW  ID of the line being requested or serviced

Behaviour:
- Reset (asynchronous, rst_n low):
  - CTRL=0, IEN=0, IPD=0, rr_ptr=0, FSM=IDLE.
  - irq_o=0, irq_id_o=0, data_o=0.
- Registers:
  - 0x00 CTRL (RW): [0] GIE global enable; [1] RR, 1 = round-robin, 0 = fixed with lowest index winning.
  - 0x04 IEN (RW): [NIRQ-1:0] per-line enable.
  - 0x08 IPD (R/W1C): pending bits.
  - 0x0C CLAIM (R): read returns {valid[31], zeros, id[IDW-1:0]}.
  - 0x10 EOI (W): data_i[IDW-1:0] = ID being completed.
  - Unused bits read 0. Unmapped offsets read 0; writes to them are ignored.
- Pending latch:
  - IPD[i] is set the edge after irq_i[i]=1, regardless of IEN and GIE.
  - A pulse on a line that is already pending is lost; there is no counting.
  - A set and a clear (W1C or claim) on the same bit in the same cycle: set wins.
- Eligibility and arbitration:
  - elig = IPD & IEN.
  - Fixed mode: winner is the lowest set index of elig.
  - RR mode: search starts at rr_ptr and wraps at NIRQ-1 -> 0.
  - rr_ptr becomes (cur_id+1) mod NIRQ on an accepted EOI. rr_ptr is unchanged in fixed mode.
- FSM (registered, 3 states):
  - IDLE: irq_o=0. If GIE && |elig, latch the winner into cur_id and go to REQ. irq_o rises 2 cycles after the irq_i pulse edge.
  - REQ: irq_o=1, irq_id_o=cur_id.
    - CLAIM read: data_o={1,cur_id}, clear IPD[cur_id], go to SERV.
    - If GIE=0, or IPD[cur_id] or IEN[cur_id] drops before the claim: go to IDLE, irq_o=0 next cycle. Arbitration then re-runs from IDLE.
    - A higher-priority line arriving in REQ does not preempt; cur_id stays stable until claim or abandon.
  - SERV: irq_o=0, irq_id_o=cur_id.
    - EOI write with id==cur_id: go to IDLE and update rr_ptr.
    - EOI write with a mismatched id: ignored, stay in SERV.
    - GIE=0 does not leave SERV; only a matching EOI does.
    - A new pulse on cur_id re-sets IPD and is serviced after the EOI.
  - A CLAIM read in IDLE or SERV returns 0 with no side effect. An EOI write in IDLE or REQ is ignored.
- Read path:
  - data_o is updated only when rd_i=1; otherwise it holds.
  - IPD reads return the pre-edge value.
  - The claim side effect happens on the same edge that captures data_o.
- A simultaneous read and write in one cycle are both performed. A W1C to IPD in the same cycle as a claim read on the same bit: the bit is cleared once.

Test Plan:
1. Reset, IEN=0x0001, CTRL=0x1, pulse irq_i[0] at edge N -> IPD=0x0001 after N; irq_o=1, irq_id_o=0 after N+2; CLAIM reads 0x80000000; IPD=0; irq_o=0 → write EOI=0 -> IDLE.
2. Fixed priority: IEN=0xFFFF, pulse lines 5 and 3 together -> claims return 3, then 5 after EOI 3; EOI=7 while serving 5 is ignored (state stays SERV).
3. RR mode: CTRL=0x3, lines 2 and 9 held pending continuously via repeated pulses -> claim sequence 2,9,2,9.
4. Abandon: in REQ with id=4, W1C IPD=0x0010 -> irq_o falls next cycle, CLAIM reads 0; same check with a GIE=0 write.
5. Collision: pulse irq_i[6] in the same cycle as a W1C of bit 6 -> IPD[6]=1; pulse while the line is pending -> one claim only.
6. Mid-operation reset: assert rst_n low in SERV -> all outputs 0 immediately, IEN=0, pending cleared, FSM=IDLE.
